// File: rtl/y86_alu_pkg.sv
// Shared defaults and FSM state encoding for the sequential Y86 subtract unit.
package y86_alu_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_slice8.sv
// Combinational SLICE-bit ripple-carry adder made of 1-bit full adders;
// the top time-multiplexes one instance across all operand slices.
module sub_slice8 #(
  parameter int SLICE = y86_alu_pkg::DEF_SLICE
) (
  input  logic [SLICE-1:0] a_slice,
  input  logic [SLICE-1:0] b_slice,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum[i]   = a_slice[i] ^ b_slice[i] ^ c_s[i];
    assign c_s[i+1] = (a_slice[i] & b_slice[i]) | (c_s[i] & (a_slice[i] ^ b_slice[i]));
  end

  assign cout = c_s[SLICE];

endmodule

// File: rtl/sub_64_seq.sv
// Multi-cycle signed subtractor: a - b computed as a + ~b + 1, one SLICE per
// clock through a shared slice adder, with Y86-style OF/ZF/SF flags.
module sub_64_seq
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zf,
  output logic             sf
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  int               idx_s;
  logic [SLICE-1:0] a_sl_s;
  logic [SLICE-1:0] b_sl_s;
  logic [SLICE-1:0] sum_s;
  logic             cout_s;

  assign idx_s  = int'(cnt_q) * SLICE;
  assign a_sl_s = a_q[idx_s +: SLICE];
  assign b_sl_s = nb_q[idx_s +: SLICE];

  sub_slice8 #(.SLICE(SLICE)) u_slice (
    .a_slice (a_sl_s),
    .b_slice (b_sl_s),
    .cin     (carry_q),
    .sum     (sum_s),
    .cout    (cout_s)
  );

  // Next-state, slice accumulation and flag computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    nb_d     = nb_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zf_d     = zf_q;
    sf_d     = sf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[idx_s +: SLICE] = sum_s;
        carry_d = cout_s;
        if (cnt_q == LAST) begin
          // Final carry-out is dropped; result is taken modulo 2^WIDTH.
          state_d  = DONE;
          cnt_d    = '0;
          result_d = acc_d;
          // nb_q holds ~b, so equal MSBs here mean a and b differ in sign.
          ovf_d    = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
          zf_d     = (acc_d == '0);
          sf_d     = acc_d[WIDTH-1];
        end else begin
          state_d = RUN;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      nb_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;
  assign zf       = zf_q;
  assign sf       = sf_q;

endmodule

// File: tb/tb_sub_64_seq.sv
// Scoreboard bench for sub_64_seq: stimulus pushes expected results computed
// with plain arithmetic; a negedge monitor pops and compares on done.
module tb_sub_64_seq;

  localparam logic [63:0] MIN_S = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX_S = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] a, b;
  logic        busy, done, overflow, zf, sf;
  logic [63:0] result;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    logic        zf;
    logic        sf;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_acc = -100;
  logic [63:0] hold_res = 64'd0;
  logic        hold_ovf = 1'b0, hold_zf = 1'b0, hold_sf = 1'b0;
  logic [63:0] dut_res = 64'd0;
  logic        dut_ovf = 1'b0, dut_zf = 1'b0, dut_sf = 1'b0;

  sub_64_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .zf       (zf),
    .sf       (sf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare busy every cycle, pop the scoreboard on done, otherwise
  // require that the visible result and flags hold their last done values.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1) begin
      check("busy", 64'(busy), 64'((cyc >= last_acc) && (cyc <= last_acc + 7)));
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.due));
          check("result", result, e.res);
          check("overflow", 64'(overflow), 64'(e.ovf));
          check("zf", 64'(zf), 64'(e.zf));
          check("sf", 64'(sf), 64'(e.sf));
          hold_res = e.res; hold_ovf = e.ovf; hold_zf = e.zf; hold_sf = e.sf;
          dut_res  = result; dut_ovf = overflow; dut_zf = zf; dut_sf = sf;
        end
      end else begin
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
          check("missing_done", 64'(done), 64'd1);
          void'(sb_q.pop_front());
        end
        check("held_result", result, hold_res);
        check("held_flags", {61'd0, overflow, zf, sf}, {61'd0, hold_ovf, hold_zf, hold_sf});
      end
    end
  end

  // Drive one cycle of inputs (called at negedge+1) and predict acceptance:
  // a start is taken unless a previous one was accepted within the last 8 edges.
  task automatic drive(input logic s, input logic [63:0] av, input logic [63:0] bv);
    int   e_edge;
    exp_t x;
    start  = s;
    a      = av;
    b      = bv;
    e_edge = cyc + 1;
    if (s && (e_edge >= last_acc + 9)) begin
      x.res = av - bv;
      x.ovf = (av[63] != bv[63]) && (x.res[63] != av[63]);
      x.zf  = (x.res == 64'd0);
      x.sf  = x.res[63];
      x.due = e_edge + 8;
      sb_q.push_back(x);
      last_acc = e_edge;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() > 0 && n < 40) begin
      drive(1'b0, $urandom, $urandom);
      n++;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  task automatic expect_last(input string name, input logic [63:0] r,
                             input logic o, input logic z, input logic s);
    check({name, "_result"}, dut_res, r);
    check({name, "_flags"}, {61'd0, dut_ovf, dut_zf, dut_sf}, {61'd0, o, z, s});
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {62'd0, busy, done}, 64'd0);
    check({name, "_result"}, result, 64'd0);
    check({name, "_flags"}, {61'd0, overflow, zf, sf}, 64'd0);
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return MIN_S;
      2:       return MAX_S;
      3:       return ONES;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin : stimulus
    logic [63:0] av, bv;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 64'd0;
    b     = 64'd0;
    #2;
    check_all_zero("reset_async");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // 5 - 3 accepted on the first edge after reset release
    drive(1'b1, 64'd5, 64'd3);
    wait_idle();
    expect_last("sub_5_3", 64'd2, 1'b0, 1'b0, 1'b0);

    drive(1'b1, MIN_S, 64'd1);
    wait_idle();
    expect_last("min_minus_1", MAX_S, 1'b1, 1'b0, 1'b0);

    drive(1'b1, MAX_S, ONES);
    wait_idle();
    expect_last("max_minus_m1", MIN_S, 1'b1, 1'b0, 1'b1);

    drive(1'b1, 64'h1234, 64'h1234);
    wait_idle();
    expect_last("equal", 64'd0, 1'b0, 1'b1, 1'b0);

    // restart attempt and operand changes mid-run must be ignored
    drive(1'b1, ONES, MIN_S);
    drive(1'b0, 64'd7, 64'd9);
    drive(1'b0, 64'd0, 64'd0);
    drive(1'b1, 64'd0, 64'd0);
    drive(1'b0, 64'd123, 64'd456);
    wait_idle();
    expect_last("m1_minus_min", MAX_S, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a run aborts it
    drive(1'b1, 64'd5, 64'd3);
    repeat (4) drive(1'b0, 64'd0, 64'd0);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_midrun");
    sb_q.delete();
    last_acc = -100;
    hold_res = 64'd0; hold_ovf = 1'b0; hold_zf = 1'b0; hold_sf = 1'b0;
    dut_res  = 64'd0; dut_ovf  = 1'b0; dut_zf  = 1'b0; dut_sf  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) drive(1'b0, 64'd0, 64'd0);
    drive(1'b1, 64'd5, 64'd3);
    wait_idle();
    expect_last("after_reset", 64'd2, 1'b0, 1'b0, 1'b0);

    // start held high: second operation accepted in the done cycle
    drive(1'b1, 64'd1, 64'd2);
    repeat (8) drive(1'b1, 64'd1, 64'd2);
    expect_last("b2b_first", ONES, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'd2, 64'd1);
    wait_idle();
    expect_last("b2b_second", 64'd1, 1'b0, 1'b0, 1'b0);

    // randomized traffic, including starts that land while busy
    repeat (400) begin
      av = rnd_operand();
      bv = ($urandom_range(0, 7) == 0) ? av : rnd_operand();
      drive($urandom_range(0, 3) == 0, av, bv);
    end
    wait_idle();

    start = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
